// File: rtl/loop_index_gen.sv
// Hardware for-loop sequencer: streams i = init; i CMP limit; i += step over a
// valid/ready index stream, with break, zero-trip handling and an optional iteration cap.
module loop_index_gen #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_ITERS = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_init,
  input  logic [WIDTH-1:0]     i_limit,
  input  logic [WIDTH-1:0]     i_step,
  input  logic [1:0]           i_cmp,
  input  logic                 i_brk,
  output logic                 o_busy,
  output logic                 o_idx_valid,
  input  logic                 i_idx_ready,
  output logic [WIDTH-1:0]     o_idx,
  output logic                 o_idx_last,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_final_idx,
  output logic [CNT_WIDTH-1:0] o_iter_count,
  output logic                 o_aborted
);

  // state   | meaning
  // S_IDLE  | waiting for start; results held
  // S_CHECK | evaluate condition on init (zero-trip detection)
  // S_EMIT  | presenting idx to consumer
  // S_DONE  | one-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_ITERS);

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_idx, r_limit, r_step, r_final;
  logic [1:0]           r_cmp;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_aborted;

  logic [WIDTH-1:0]     w_idx_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_cond_cur, w_cond_nxt, w_hs, w_cap_hit;

  function automatic logic f_cond(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [1:0] c);
    logic r;
    case (c)
      2'd0:    r = $signed(a) <  $signed(b);
      2'd1:    r = $signed(a) <= $signed(b);
      2'd2:    r = $signed(a) >  $signed(b);
      default: r = $signed(a) >= $signed(b);
    endcase
    return r;
  endfunction

  assign w_idx_nxt  = r_idx + r_step;
  assign w_cond_cur = f_cond(r_idx, r_limit, r_cmp);
  assign w_cond_nxt = f_cond(w_idx_nxt, r_limit, r_cmp);
  assign w_hs       = (r_state == S_EMIT) && i_idx_ready;
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);
  assign w_cap_hit  = (MAX_ITERS != 0) && (w_cnt_inc == LP_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_cond_cur ? S_EMIT : S_DONE;
      S_EMIT:  if (w_hs && (i_brk || w_cap_hit || !w_cond_nxt)) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx     <= '0;
      r_limit   <= '0;
      r_step    <= '0;
      r_cmp     <= '0;
      r_final   <= '0;
      r_cnt     <= '0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_idx     <= i_init;
          r_limit   <= i_limit;
          r_step    <= i_step;
          r_cmp     <= i_cmp;
          r_cnt     <= '0;
          r_aborted <= 1'b0;
        end
        S_CHECK: if (!w_cond_cur) r_final <= r_idx;
        S_EMIT: if (w_hs) begin
          r_cnt <= w_cnt_inc;
          // break wins over the cap; break reports the un-stepped index
          if (i_brk) begin
            r_final <= r_idx;
          end else if (w_cap_hit) begin
            r_aborted <= 1'b1;
            r_final   <= w_idx_nxt;
          end else if (!w_cond_nxt) begin
            r_final <= w_idx_nxt;
          end else begin
            r_idx <= w_idx_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state == S_CHECK) || (r_state == S_EMIT);
  assign o_idx_valid  = (r_state == S_EMIT);
  assign o_idx        = r_idx;
  assign o_idx_last   = (r_state == S_EMIT) && !w_cond_nxt;
  assign o_done       = (r_state == S_DONE);
  assign o_final_idx  = r_final;
  assign o_iter_count = r_cnt;
  assign o_aborted    = r_aborted;

endmodule
